ex_div_seq: RTL

EX_DIV_SEQ -- requirements
Module: ex_div_seq

---
 rtl/ex_div_seq_pkg.sv | 22 ++
 rtl/ex_div_seq.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ex_div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM encodings, handshake constants
// and the operand-magnitude helper.
package ex_div_seq_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Magnitude of an operand; unsigned mode passes it through untouched.
  function automatic logic [31:0] div_abs(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_div_seq.sv
// Multi-cycle 32/32 restoring divider for the EX stage: one quotient bit per clock,
// stalls the pipeline while busy and can be annulled by a flush.
module ex_div_seq
  import ex_div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dsor_q, dsor_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;

  logic [32:0] trial;
  logic [31:0] rem_nx, quo_nx;
  logic        accept;

  assign accept = (start_i == DivStart) && !annul_i;

  // One restoring step: shift the next dividend bit into the remainder, keep the
  // subtraction only if it did not borrow.
  always_comb begin
    trial = {rem_q, quo_q[31]} - {1'b0, dsor_q};
    if (!trial[32]) begin
      rem_nx = trial[31:0];
      quo_nx = {quo_q[30:0], 1'b1};
    end else begin
      rem_nx = {rem_q[30:0], quo_q[31]};
      quo_nx = {quo_q[30:0], 1'b0};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsor_d    = dsor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      DivFree: begin
        if (accept) begin
          cnt_d     = 6'd0;
          rem_d     = 32'd0;
          quo_d     = div_abs(opdata1_i, signed_div_i);
          dsor_d    = div_abs(opdata2_i, signed_div_i);
          neg_quo_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
          neg_rem_d = signed_div_i && opdata1_i[31];
          result_d  = 64'd0;
          state_d   = (opdata2_i == 32'd0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          result_d = 64'd0;
          state_d  = DivEnd;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            // Sign fix-up; 0x80000000 / -1 wraps back to 0x80000000 naturally.
            result_d = {neg_rem_q ? (~rem_nx + 32'd1) : rem_nx,
                        neg_quo_q ? (~quo_nx + 32'd1) : quo_nx};
            state_d  = DivEnd;
          end
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          state_d = DivFree;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= 6'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dsor_q    <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 64'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsor_q    <= dsor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
  assign result_o = (state_q == DivEnd) ? result_q : 64'd0;

  // Reset is folded in so a held start_i cannot raise a stall while in reset.
  assign stallreq_o = rst && ((state_q == DivOn) || (state_q == DivByZero) ||
                              ((state_q == DivFree) && accept));

endmodule
